// File: rtl/reg_file_2r1w_if.sv
// Bus interface for reg_file_2r1w: write port, dual read port and clear control.
// The master modport drives requests; the slave modport belongs to the register file.
interface reg_file_2r1w_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  clr;
    logic                  busy;
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr_w;
    logic [DATA_WIDTH-1:0] data_w;
    logic                  read;
    logic [ADDR_WIDTH-1:0] addr_r1;
    logic [ADDR_WIDTH-1:0] addr_r2;
    logic [DATA_WIDTH-1:0] data_r1;
    logic [DATA_WIDTH-1:0] data_r2;
    logic                  valid_r;

    modport master (
        output clr, write, addr_w, data_w, read, addr_r1, addr_r2,
        input  busy, data_r1, data_r2, valid_r
    );

    modport slave (
        input  clr, write, addr_w, data_w, read, addr_r1, addr_r2,
        output busy, data_r1, data_r2, valid_r
    );
endinterface

// File: rtl/reg_file_2r1w.sv
// Parametrised 2-read/1-write register file with registered, bypassed reads and a clear sweep.
// Optional macro REGFILE_ZERO_REG_EN hardwires entry 0 to zero.
module reg_file_2r1w_rd_port #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_mem_data,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic [DATA_WIDTH-1:0] o_data
);
    logic [DATA_WIDTH-1:0] w_next;
    logic [DATA_WIDTH-1:0] r_data;

    always_comb begin
        w_next = i_mem_data;
        if (i_wr_en && (i_wr_addr == i_addr))
            w_next = i_wr_data;
`ifdef REGFILE_ZERO_REG_EN
        // Entry 0 reads as zero even against a same-cycle write to it
        if (i_addr == '0)
            w_next = '0;
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_data <= '0;
        else if (i_rd_en)
            r_data <= w_next;
    end

    assign o_data = r_data;
endmodule

module reg_file_2r1w #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic              i_clk,
    input  logic              i_rst,
    reg_file_2r1w_if.slave    s_bus
);
    localparam int DEPTH  = 2**ADDR_WIDTH;
    localparam int NUM_RD = 2;

    typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic                  r_busy;
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                                  w_op;
    logic                                  w_wr_en;
    logic                                  w_wr_commit;
    logic                                  w_rd_en;
    logic [NUM_RD-1:0][ADDR_WIDTH-1:0]     w_rd_addr;
    logic [NUM_RD-1:0][DATA_WIDTH-1:0]     w_rd_mem;
    logic [NUM_RD-1:0][DATA_WIDTH-1:0]     w_rd_data;

    // A CLR request in IDLE swallows any read/write in the same cycle
    assign w_op    = (r_state == ST_IDLE) && !s_bus.clr;
    assign w_wr_en = w_op && s_bus.write;
    assign w_rd_en = w_op && s_bus.read;
`ifdef REGFILE_ZERO_REG_EN
    assign w_wr_commit = w_wr_en && (s_bus.addr_w != '0);
`else
    assign w_wr_commit = w_wr_en;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (&r_cnt) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (s_bus.clr) begin
                        r_state <= ST_CLEAR;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_CLEAR;
                    r_cnt   <= '0;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (r_state == ST_CLEAR)
                r_mem[r_cnt] <= '0;
            else if (w_wr_commit)
                r_mem[s_bus.addr_w] <= s_bus.data_w;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_valid <= 1'b0;
        else
            r_valid <= w_rd_en;
    end

    assign w_rd_addr = {s_bus.addr_r2, s_bus.addr_r1};

    generate
        for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
            assign w_rd_mem[p] = r_mem[w_rd_addr[p]];

            reg_file_2r1w_rd_port #(
                .DATA_WIDTH (DATA_WIDTH),
                .ADDR_WIDTH (ADDR_WIDTH)
            ) u_rd (
                .i_clk      (i_clk),
                .i_rst      (i_rst),
                .i_rd_en    (w_rd_en),
                .i_addr     (w_rd_addr[p]),
                .i_mem_data (w_rd_mem[p]),
                .i_wr_en    (w_wr_en),
                .i_wr_addr  (s_bus.addr_w),
                .i_wr_data  (s_bus.data_w),
                .o_data     (w_rd_data[p])
            );
        end
    endgenerate

    assign s_bus.busy    = r_busy;
    assign s_bus.valid_r = r_valid;
    assign s_bus.data_r1 = w_rd_data[0];
    assign s_bus.data_r2 = w_rd_data[1];
endmodule

// File: tb/tb_reg_file_2r1w.sv
// Randomised scoreboard bench for reg_file_2r1w against an array-based reference model.
module tb_reg_file_2r1w;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    typedef struct packed {
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
    } rd_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reg_file_2r1w_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    reg_file_2r1w #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .s_bus (bus)
    );

    int            checks = 0;
    int            errors = 0;
    rd_exp_t       exp_q[$];
    logic [DW-1:0] mem_m [DEPTH];
    int            busy_left = 0;
    logic          exp_valid = 1'b0;
    logic [DW-1:0] hold_d1 = '0;
    logic [DW-1:0] hold_d2 = '0;
    logic          mon_en = 1'b0;

    task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a, input logic w,
                                               input logic [AW-1:0] aw, input logic [DW-1:0] dw);
`ifdef REGFILE_ZERO_REG_EN
        if (a == 0) return '0;
`endif
        if (w && aw == a) return dw;
        return mem_m[a];
    endfunction

    task automatic step(input logic r, input logic c, input logic w, input logic [AW-1:0] aw,
                        input logic [DW-1:0] dw, input logic rd, input logic [AW-1:0] a1,
                        input logic [AW-1:0] a2);
        rd_exp_t e;
        logic    idle;
        @(negedge clk);
        rst = r; bus.clr = c; bus.write = w; bus.addr_w = aw; bus.data_w = dw;
        bus.read = rd; bus.addr_r1 = a1; bus.addr_r2 = a2;
        idle = (busy_left == 0);
        @(posedge clk);
        #1;
        if (r || (idle && c)) begin
            busy_left = DEPTH;
            foreach (mem_m[i]) mem_m[i] = '0;
            exp_valid = 1'b0;
            if (r) begin
                hold_d1 = '0;
                hold_d2 = '0;
            end
        end else if (!idle) begin
            busy_left--;
            exp_valid = 1'b0;
        end else begin
            exp_valid = rd;
            if (rd) begin
                e.d1 = ref_read(a1, w, aw, dw);
                e.d2 = ref_read(a2, w, aw, dw);
                exp_q.push_back(e);
                hold_d1 = e.d1;
                hold_d2 = e.d2;
            end
`ifdef REGFILE_ZERO_REG_EN
            if (w && aw != 0) mem_m[aw] = dw;
`else
            if (w) mem_m[aw] = dw;
`endif
        end
    endtask

    task automatic nop();
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic rd2(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, a1, a2);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        step(1'b0, 1'b0, 1'b1, a, d, 1'b0, '0, '0);
    endtask

    // Count busy cycles while hammering the ports with random traffic that must be ignored
    task automatic wait_busy(input string nm);
        int n = 0;
        while (bus.busy === 1'b1 && n < 100) begin
            n++;
            step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom),
                 $urandom, 1'($urandom_range(0, 1)), AW'($urandom), AW'($urandom));
        end
        check(nm, DW'(n), DW'(DEPTH));
    endtask

    task automatic read_all();
        for (int a = 0; a < DEPTH; a++) rd2(AW'(a), AW'(DEPTH - 1 - a));
    endtask

    always @(negedge clk) begin
        rd_exp_t e;
        if (mon_en) begin
            check("busy", DW'(bus.busy), DW'(busy_left != 0));
            check("valid_r", DW'(bus.valid_r), DW'(exp_valid));
            if (bus.valid_r === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_read: got valid_r=1 expected no pending read");
                end else begin
                    e = exp_q.pop_front();
                    check("data_r1", bus.data_r1, e.d1);
                    check("data_r2", bus.data_r2, e.d2);
                end
            end else begin
                check("hold_r1", bus.data_r1, hold_d1);
                check("hold_r2", bus.data_r2, hold_d2);
            end
        end
    end

    initial begin
        bus.clr = 1'b0; bus.write = 1'b0; bus.addr_w = '0; bus.data_w = '0;
        bus.read = 1'b0; bus.addr_r1 = '0; bus.addr_r2 = '0;

        // Reset and initial sweep
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        mon_en = 1'b1;
        wait_busy("busy_after_rst");
        read_all();

        // Write then read same entry on both ports, then hold
        wr(5'd7, 32'hDEADBEEF);
        rd2(5'd7, 5'd7);
        nop();

        // Bypass on port 1, stored value on port 2
        wr(5'd3, 32'h5);
        step(1'b0, 1'b0, 1'b1, 5'd9, 32'h12345678, 1'b1, 5'd9, 5'd3);
        nop();

        // Fill, then CLR with a concurrent write that must be dropped
        for (int a = 1; a < DEPTH; a++) wr(AW'(a), $urandom | 32'h1);
        read_all();
        step(1'b0, 1'b1, 1'b1, 5'd4, 32'hCAFEF00D, 1'b1, 5'd4, 5'd4);
        wait_busy("busy_after_clr");
        read_all();

        // Reset in the middle of a sweep restarts it
        for (int a = 0; a < DEPTH; a++) wr(AW'(a), $urandom);
        step(1'b0, 1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
        for (int i = 0; i < 10; i++) nop();
        step(1'b1, 1'b0, 1'b1, 5'd2, 32'h1, 1'b1, 5'd2, 5'd2);
        wait_busy("busy_after_mid_rst");
        read_all();

        // Entry 0 write with same-cycle read, then plain read
        step(1'b0, 1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0);
        rd2(5'd0, 5'd0);
        nop();

        // Random traffic, including occasional clears and resets
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 79) == 0),
                 1'($urandom_range(0, 1)), AW'($urandom), $urandom,
                 1'($urandom_range(0, 2) != 0), AW'($urandom), AW'($urandom));
        end
        for (int i = 0; i < 40; i++) nop();
        read_all();
        nop();
        nop();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending reads expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
